// File: rtl/mm_cmd_seq.sv
// Command front-end and 4x4 tile sequencer for the DiP systolic matmul engine.
// Optional MM_PERF_CNT_EN adds resp_cycles (cycles spent in ISSUE+WAIT_DONE).
module mm_cmd_seq #(
  parameter int unsigned AW   = 10,
  parameter int unsigned TILE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_m,
  input  logic [3:0]    cmd_n,
  input  logic [3:0]    cmd_k,
  input  logic [AW-1:0] cmd_base_in1,
  input  logic [AW-1:0] cmd_base_in2,
  input  logic [AW-1:0] cmd_base_out,
  output logic [3:0]    chk_m,
  output logic [3:0]    chk_n,
  output logic [3:0]    chk_k,
  output logic [AW-1:0] chk_base_in1,
  output logic [AW-1:0] chk_base_in2,
  output logic [AW-1:0] chk_base_out,
  output logic          err_cal,
  input  logic          err_found,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [AW-1:0] tile_addr_a,
  output logic [AW-1:0] tile_addr_b,
  output logic [AW-1:0] tile_addr_c,
  output logic          tile_first,
  output logic          tile_last,
  input  logic          tile_done,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_err
`ifdef MM_PERF_CNT_EN
  ,
  output logic [15:0]   resp_cycles
`endif
);

  localparam int unsigned TileShift = $clog2(TILE);

  typedef enum logic [2:0] {StIdle, StCheck, StEval, StIssue, StWaitDone, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    m_q, m_d, n_q, n_d, k_q, k_d;
  logic [AW-1:0] b1_q, b1_d, b2_q, b2_d, bo_q, bo_d;
  logic [3:0]    mi_q, mi_d, ki_q, ki_d, ni_q, ni_d;
  logic          resp_err_q, resp_err_d;
  logic [3:0]    m_tiles, n_tiles, k_tiles;
  logic          last_n;

  assign m_tiles = m_q >> TileShift;
  assign n_tiles = n_q >> TileShift;
  assign k_tiles = k_q >> TileShift;
  assign last_n  = (ni_q == n_tiles - 4'd1);

  // Tile origins: TILE * (row_tile * row_stride + col_tile), all in AW bits.
  assign tile_addr_a = b1_q + AW'(TILE) * (AW'(mi_q) * AW'(n_q) + AW'(ni_q));
  assign tile_addr_b = b2_q + AW'(TILE) * (AW'(ni_q) * AW'(k_q) + AW'(ki_q));
  assign tile_addr_c = bo_q + AW'(TILE) * (AW'(mi_q) * AW'(k_q) + AW'(ki_q));

  assign cmd_ready    = (state_q == StIdle);
  assign err_cal      = (state_q == StCheck);
  assign tile_valid   = (state_q == StIssue);
  assign tile_first   = (state_q == StIssue) && (ni_q == 4'd0);
  assign tile_last    = (state_q == StIssue) && last_n;
  assign resp_valid   = (state_q == StResp);
  assign resp_err     = resp_err_q;
  assign chk_m        = m_q;
  assign chk_n        = n_q;
  assign chk_k        = k_q;
  assign chk_base_in1 = b1_q;
  assign chk_base_in2 = b2_q;
  assign chk_base_out = bo_q;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    bo_d       = bo_q;
    mi_d       = mi_q;
    ki_d       = ki_q;
    ni_d       = ni_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          m_d     = cmd_m;
          n_d     = cmd_n;
          k_d     = cmd_k;
          b1_d    = cmd_base_in1;
          b2_d    = cmd_base_in2;
          bo_d    = cmd_base_out;
          state_d = StCheck;
        end
      end
      StCheck: state_d = StEval;
      StEval: begin
        if (err_found) begin
          resp_err_d = 1'b1;
          state_d    = StResp;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (tile_ready) begin
          if (last_n) state_d = StWaitDone;
          else        ni_d    = ni_q + 4'd1;
        end
      end
      StWaitDone: begin
        if (tile_done) begin
          ni_d = 4'd0;
          if (ki_q + 4'd1 == k_tiles) begin
            ki_d = 4'd0;
            if (mi_q + 4'd1 == m_tiles) begin
              mi_d    = 4'd0;
              state_d = StResp;
            end else begin
              mi_d    = mi_q + 4'd1;
              state_d = StIssue;
            end
          end else begin
            ki_d    = ki_q + 4'd1;
            state_d = StIssue;
          end
        end
      end
      StResp: begin
        if (resp_ready) begin
          mi_d       = 4'd0;
          ki_d       = 4'd0;
          ni_d       = 4'd0;
          resp_err_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      bo_q       <= '0;
      mi_q       <= '0;
      ki_q       <= '0;
      ni_q       <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      k_q        <= k_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      bo_q       <= bo_d;
      mi_q       <= mi_d;
      ki_q       <= ki_d;
      ni_q       <= ni_d;
      resp_err_q <= resp_err_d;
    end
  end

`ifdef MM_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StIdle && cmd_valid) begin
      cyc_d = 16'd0;
    end else if ((state_q == StIssue || state_q == StWaitDone) && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= 16'd0;
    else     cyc_q <= cyc_d;
  end

  assign resp_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mm_cmd_seq.sv
// Scoreboard bench for mm_cmd_seq: stimulus pushes expected tile steps and
// responses; a negedge monitor pops and compares on each handshake.
module tb_mm_cmd_seq;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_m = '0, cmd_n = '0, cmd_k = '0;
  logic [AW-1:0] cmd_base_in1 = '0, cmd_base_in2 = '0, cmd_base_out = '0;
  logic [3:0]    chk_m, chk_n, chk_k;
  logic [AW-1:0] chk_base_in1, chk_base_in2, chk_base_out;
  logic          err_cal;
  logic          err_found;
  logic          tile_valid;
  logic          tile_ready = 1'b1;
  logic [AW-1:0] tile_addr_a, tile_addr_b, tile_addr_c;
  logic          tile_first, tile_last;
  logic          tile_done;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_err;
`ifdef MM_PERF_CNT_EN
  logic [15:0]   resp_cycles;
`endif

  mm_cmd_seq #(.AW(AW), .TILE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_m        (cmd_m),
    .cmd_n        (cmd_n),
    .cmd_k        (cmd_k),
    .cmd_base_in1 (cmd_base_in1),
    .cmd_base_in2 (cmd_base_in2),
    .cmd_base_out (cmd_base_out),
    .chk_m        (chk_m),
    .chk_n        (chk_n),
    .chk_k        (chk_k),
    .chk_base_in1 (chk_base_in1),
    .chk_base_in2 (chk_base_in2),
    .chk_base_out (chk_base_out),
    .err_cal      (err_cal),
    .err_found    (err_found),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_addr_a  (tile_addr_a),
    .tile_addr_b  (tile_addr_b),
    .tile_addr_c  (tile_addr_c),
    .tile_first   (tile_first),
    .tile_last    (tile_last),
    .tile_done    (tile_done),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_err     (resp_err)
`ifdef MM_PERF_CNT_EN
    ,
    .resp_cycles  (resp_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int c; int f; int l; } tile_t;
  typedef struct { int err; int cyc; } resp_t;
  tile_t exp_tile[$];
  resp_t exp_resp[$];

  int checks = 0;
  int failures = 0;
  int tile_cnt = 0;
  int resp_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Checker model: verdict registered on the err_cal cycle.
  logic reject = 1'b0;
  always @(posedge clk) err_found <= err_cal & reject;

  // Datapath model: tile_done three cycles after a last-step handshake.
  logic done_en = 1'b1;
  int   done_cnt = 0;
  always @(posedge clk) begin
    if (rst) done_cnt <= 0;
    else if (tile_valid && tile_ready && tile_last) done_cnt <= 3;
    else if (done_cnt > 0) done_cnt <= done_cnt - 1;
  end
  assign tile_done = done_en && (done_cnt == 1);

  always @(negedge clk) begin
    if (!rst && tile_valid && tile_ready) begin
      tile_cnt++;
      if (exp_tile.size() == 0) begin
        chk("tile_unexpected", 1, 0);
      end else begin
        tile_t e;
        e = exp_tile.pop_front();
        chk("tile_a", int'(tile_addr_a), e.a);
        chk("tile_b", int'(tile_addr_b), e.b);
        chk("tile_c", int'(tile_addr_c), e.c);
        chk("tile_first", int'(tile_first), e.f);
        chk("tile_last", int'(tile_last), e.l);
      end
    end
    if (!rst && resp_valid && resp_ready) begin
      resp_cnt++;
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        chk("resp_err", int'(resp_err), r.err);
`ifdef MM_PERF_CNT_EN
        chk("resp_cycles", int'(resp_cycles), r.cyc);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_tile(input int a, input int b, input int c, input int f, input int l);
    tile_t t;
    t.a = a; t.b = b; t.c = c; t.f = f; t.l = l;
    exp_tile.push_back(t);
  endtask

  task automatic push_resp(input int err, input int cyc);
    resp_t r;
    r.err = err; r.cyc = cyc;
    exp_resp.push_back(r);
  endtask

  task automatic send(input int m, input int n, input int k,
                      input int b1, input int b2, input int bo);
    cmd_m = 4'(m); cmd_n = 4'(n); cmd_k = 4'(k);
    cmd_base_in1 = AW'(b1); cmd_base_in2 = AW'(b2); cmd_base_out = AW'(bo);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("err_cal_pulse", int'(err_cal), 1);
    chk("cmd_ready_drop", int'(cmd_ready), 0);
    chk("chk_m", int'(chk_m), m);
    chk("chk_base_in2", int'(chk_base_in2), b2);
    step();
    chk("err_cal_one_cycle", int'(err_cal), 0);
  endtask

  task automatic wait_resp(input int target);
    int cyc = 0;
    while (resp_cnt < target && cyc < 500) begin
      step();
      cyc++;
    end
    if (resp_cnt < target) chk("resp_timeout", resp_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_err_cal", int'(err_cal), 0);
    chk("rst_tile_valid", int'(tile_valid), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_addr_a", int'(tile_addr_a), 0);

    // 4x4x4, single tile step.
    push_tile(0, 16, 32, 1, 1);
    push_resp(0, 4);
    send(4, 4, 4, 0, 16, 32);
    wait_resp(1);

    // Rejected command, response held by resp_ready low.
    reject = 1'b1;
    resp_ready = 1'b0;
    push_resp(1, 0);
    send(3, 4, 4, 0, 16, 32);
    begin
      int cyc = 0;
      while (!resp_valid && cyc < 20) begin step(); cyc++; end
    end
    chk("rej_resp_valid", int'(resp_valid), 1);
    for (int i = 0; i < 3; i++) begin
      chk("rej_no_tile", int'(tile_valid), 0);
      chk("rej_cmd_ready_low", int'(cmd_ready), 0);
      step();
    end
    resp_ready = 1'b1;
    reject = 1'b0;
    wait_resp(2);
    chk("rej_cmd_ready_back", int'(cmd_ready), 1);

    // 8x8x4: mi outer, ki middle, ni inner.
    push_tile(0, 100, 200, 1, 0);
    push_tile(4, 116, 200, 0, 1);
    push_tile(32, 100, 216, 1, 0);
    push_tile(36, 116, 216, 0, 1);
    push_resp(0, 10);
    send(8, 8, 4, 0, 100, 200);
    wait_resp(3);

    // Back-pressure: tile_ready low for 5 cycles on the first step.
    tile_ready = 1'b0;
    push_tile(0, 16, 32, 1, 1);
    push_resp(0, 9);
    send(4, 4, 4, 0, 16, 32);
    begin
      int cyc = 0;
      while (!tile_valid && cyc < 20) begin step(); cyc++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", int'(tile_valid), 1);
      chk("stall_a", int'(tile_addr_a), 0);
      chk("stall_b", int'(tile_addr_b), 16);
      chk("stall_c", int'(tile_addr_c), 32);
      chk("stall_first_last", int'({tile_first, tile_last}), 3);
      step();
    end
    tile_ready = 1'b1;
    wait_resp(4);
    chk("stall_tile_count", tile_cnt, 6);

    // Reset while waiting for tile_done.
    done_en = 1'b0;
    push_tile(0, 16, 32, 1, 1);
    send(4, 4, 4, 0, 16, 32);
    begin
      int cyc = 0;
      while (tile_cnt < 7 && cyc < 20) begin step(); cyc++; end
    end
    chk("rw_tile_seen", tile_cnt, 7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_cmd_ready", int'(cmd_ready), 1);
    chk("rw_resp_valid", int'(resp_valid), 0);
    chk("rw_tile_valid", int'(tile_valid), 0);
    chk("rw_err_cal", int'(err_cal), 0);
    chk("rw_chk_m", int'(chk_m), 0);
    chk("rw_addr_b", int'(tile_addr_b), 0);
    chk("rw_tile_first", int'(tile_first), 0);
    done_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rw_no_resp", resp_cnt, 4);

    // Normal command after the reset.
    push_tile(0, 16, 32, 1, 1);
    push_resp(0, 4);
    send(4, 4, 4, 0, 16, 32);
    wait_resp(5);

    step();
    chk("tile_queue_empty", exp_tile.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
